systolic_pe: RTL and testbench

- Weight-stationary processing element (MAC cell) for the systolic array.
- Holds one stationary weight and forwards activations one cell to the right with a 1-cycle delay.
- Adds its product a_in × weight to the incoming partial sum and passes the result down the column, registered.
- Tiled in a 2-D grid; activations flow along rows, partial sums along columns, and weights are loaded down columns.

---
 rtl/systolic_pe.sv | 65 ++++++
 tb/tb_systolic_pe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/systolic_pe.sv
// Weight-stationary MAC cell: holds one weight, forwards activations right, sums down the column.
// Latency: 1 cycle a_in/psum_in -> a_out/psum_out; weight_out follows the weight register directly.
// Backpressure: none; the datapath advances every clock and the neighbours must keep pace.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              weight_load,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] weight_out,
    output logic [ACC_W-1:0]  psum_out
);

    localparam int PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] weight_reg;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  psum_nxt;

    // Operands are widened first so the product keeps all 2*DATA_W bits.
    assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, weight_reg};

    generate
        if (ACC_W > PROD_W) begin : g_prod_pad
            assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, prod};
        end else if (ACC_W == PROD_W) begin : g_prod_same
            assign prod_ext = prod;
        end else begin : g_prod_trunc
            assign prod_ext = prod[ACC_W-1:0];
        end
    endgenerate

    assign psum_nxt   = psum_in + prod_ext;
    assign weight_out = weight_reg;

    // clear leaves the stationary weight alone so a tile can be flushed without reloading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_reg <= '0;
        end else if (weight_load) begin
            weight_reg <= weight_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out    <= '0;
            psum_out <= '0;
        end else if (clear) begin
            a_out    <= '0;
            psum_out <= '0;
        end else begin
            a_out    <= a_in;
            psum_out <= psum_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe with an 8-bit accumulator so wrap-around is easy to reach.
module tb_systolic_pe;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 8;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              weight_load;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] weight_in;
    logic [ACC_W-1:0]  psum_in;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] weight_out;
    logic [ACC_W-1:0]  psum_out;

    int total;
    int bad;

    systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .weight_load(weight_load),
        .a_in       (a_in),
        .weight_in  (weight_in),
        .psum_in    (psum_in),
        .a_out      (a_out),
        .weight_out (weight_out),
        .psum_out   (psum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] s_a    [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [7:0] s_ps   [9] = '{8'd0, 8'd0, 8'd0, 8'd100, 8'd100, 8'd100, 8'd50, 8'd50, 8'd50};
    logic [7:0] s_exp  [9] = '{8'd5, 8'd10, 8'd15, 8'd120, 8'd125, 8'd130, 8'd85, 8'd90, 8'd95};

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        clear       = 1'b0;
        weight_load = 1'b0;
        a_in        = '0;
        weight_in   = '0;
        psum_in     = '0;
        #12;
        chk("reset_a_out", a_out, 0);
        chk("reset_psum_out", psum_out, 0);
        chk("reset_weight_out", weight_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Build nonzero state, then hit reset between edges.
        weight_load = 1'b1; weight_in = 8'd4; a_in = 8'd6; psum_in = 8'd3;
        step();
        weight_load = 1'b0;
        step();
        chk("pre_rst_psum", psum_out, 27);
        chk("pre_rst_a", a_out, 6);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_a", a_out, 0);
        chk("async_rst_psum", psum_out, 0);
        chk("async_rst_weight", weight_out, 0);
        a_in = '0; psum_in = '0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_psum", psum_out, 0);
        chk("post_rst_weight", weight_out, 0);

        // Weight load and hold.
        weight_load = 1'b1; weight_in = 8'd5;
        step();
        chk("wload_5", weight_out, 5);
        weight_load = 1'b0; weight_in = 8'd9;
        step();
        chk("wload_hold", weight_out, 5);

        // Clear keeps the weight, next edge computes normally.
        a_in = 8'd3; psum_in = 8'd7; clear = 1'b1;
        step();
        chk("clear_psum", psum_out, 0);
        chk("clear_a", a_out, 0);
        chk("clear_weight", weight_out, 5);
        clear = 1'b0;
        step();
        chk("after_clear_psum", psum_out, 22);
        chk("after_clear_a", a_out, 3);

        // MAC stream with weight 5.
        for (int i = 0; i < 9; i++) begin
            a_in = s_a[i]; psum_in = s_ps[i];
            step();
            chk($sformatf("stream_psum_%0d", i), psum_out, s_exp[i]);
            chk($sformatf("stream_a_%0d", i), a_out, s_a[i]);
        end

        // Idle activation passes the partial sum straight through.
        a_in = 8'd0; psum_in = 8'd77;
        step();
        chk("idle_pass", psum_out, 77);

        // Wrap-around: 10 + 255*2 = 520 -> 8 mod 256.
        weight_load = 1'b1; weight_in = 8'd255; a_in = 8'd0; psum_in = 8'd0;
        step();
        weight_load = 1'b0;
        a_in = 8'd2; psum_in = 8'd10;
        step();
        chk("wrap_psum", psum_out, 8);

        // Load/compute overlap: old weight applies on the load edge.
        weight_load = 1'b1; weight_in = 8'd5; a_in = 8'd0; psum_in = 8'd0;
        step();
        weight_in = 8'd7; a_in = 8'd2; psum_in = 8'd0;
        step();
        chk("overlap_psum_old_w", psum_out, 10);
        chk("overlap_weight", weight_out, 7);
        weight_load = 1'b0;
        step();
        chk("overlap_psum_new_w", psum_out, 14);

        // Load and clear together.
        weight_load = 1'b1; weight_in = 8'd3; clear = 1'b1; a_in = 8'd4; psum_in = 8'd1;
        step();
        chk("load_clear_weight", weight_out, 3);
        chk("load_clear_psum", psum_out, 0);
        chk("load_clear_a", a_out, 0);
        weight_load = 1'b0; clear = 1'b0;
        step();
        chk("load_clear_next_psum", psum_out, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
